// File: rtl/sevenseg_to_bcd_capture.sv
// -----------------------------------------------------------------------------
// sevenseg_to_bcd_capture
//
// Purpose: takes a stream of 7-segment patterns (one digit per valid/ready
// handshake), decodes each back to a BCD nibble and packs NUM_DIGITS of them
// into a frame. Completed frames are offered on a valid/ready output together
// with a flag that marks frames containing an unrecognised pattern.
//
// Ports:
//   clk        in   system clock, all state on the rising edge
//   rst        in   synchronous active-high reset
//   seg_valid  in   seg_in holds a pattern to transfer
//   seg_in     in   [6:0] pattern {a,b,c,d,e,f,g}, active-high segments
//   seg_ready  out  block can accept a pattern this cycle
//   bcd_valid  out  completed frame present on bcd_out
//   bcd_ready  in   downstream accepts the frame
//   bcd_out    out  [4*NUM_DIGITS-1:0] frame, first digit in the MS nibble
//   frame_err  out  frame contains at least one illegal pattern (digit = F)
//   digit_cnt  out  [3:0] digits accepted in the current frame
// -----------------------------------------------------------------------------
module sevenseg_to_bcd_capture #(
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    seg_valid,
    input  logic [6:0]              seg_in,
    output logic                    seg_ready,
    output logic                    bcd_valid,
    input  logic                    bcd_ready,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    frame_err,
    output logic [3:0]              digit_cnt
);

    localparam int         W         = 4 * NUM_DIGITS;
    localparam logic [3:0] LAST_DIGIT = 4'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    // Returns {illegal, nibble}; only exact glyph matches are accepted, anything
    // else (blank, the 10..15 glyph, partial patterns) decodes to F + illegal.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'h7E:   res = 5'h00;
            7'h30:   res = 5'h01;
            7'h6D:   res = 5'h02;
            7'h79:   res = 5'h03;
            7'h33:   res = 5'h04;
            7'h5B:   res = 5'h05;
            7'h5F:   res = 5'h06;
            7'h70:   res = 5'h07;
            7'h7F:   res = 5'h08;
            7'h7B:   res = 5'h09;
            default: res = 5'h1F;
        endcase
        return res;
    endfunction

    state_e         state_q,     state_d;
    logic [W-1:0]   shift_q,     shift_d;
    logic           err_acc_q,   err_acc_d;
    logic [3:0]     cnt_q,       cnt_d;
    logic [W-1:0]   bcd_out_q,   bcd_out_d;
    logic           frame_err_q, frame_err_d;
    logic           seg_ready_q, seg_ready_d;
    logic           bcd_valid_q, bcd_valid_d;

    logic [4:0]     dec_s;
    logic           transfer_s;
    logic           err_next_s;
    logic [W-1:0]   shifted_s;

    assign dec_s      = decode_seg(seg_in);
    assign transfer_s = seg_valid & seg_ready_q;
    assign err_next_s = err_acc_q | dec_s[4];
    // Shift left by one nibble; the cast drops the oldest nibble off the top.
    assign shifted_s  = W'({shift_q, dec_s[3:0]});

    // Next-state logic for the collect/hold handshake FSM and its datapath.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        err_acc_d   = err_acc_q;
        cnt_d       = cnt_q;
        bcd_out_d   = bcd_out_q;
        frame_err_d = frame_err_q;
        seg_ready_d = seg_ready_q;
        bcd_valid_d = bcd_valid_q;
        case (state_q)
            COLLECT: begin
                if (transfer_s) begin
                    shift_d   = shifted_s;
                    err_acc_d = err_next_s;
                    if (cnt_q == LAST_DIGIT) begin
                        state_d     = HOLD;
                        cnt_d       = 4'd0;
                        bcd_out_d   = shifted_s;
                        frame_err_d = err_next_s;
                        seg_ready_d = 1'b0;
                        bcd_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else begin
                    state_d = COLLECT;
                end
            end
            HOLD: begin
                // Ready is sampled here only; re-opening the input takes a
                // full cycle, there is no same-cycle bypass.
                if (bcd_ready) begin
                    state_d     = COLLECT;
                    err_acc_d   = 1'b0;
                    seg_ready_d = 1'b1;
                    bcd_valid_d = 1'b0;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d     = COLLECT;
                cnt_d       = 4'd0;
                err_acc_d   = 1'b0;
                seg_ready_d = 1'b1;
                bcd_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= COLLECT;
            shift_q     <= '0;
            err_acc_q   <= 1'b0;
            cnt_q       <= 4'd0;
            bcd_out_q   <= '0;
            frame_err_q <= 1'b0;
            seg_ready_q <= 1'b1;
            bcd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            err_acc_q   <= err_acc_d;
            cnt_q       <= cnt_d;
            bcd_out_q   <= bcd_out_d;
            frame_err_q <= frame_err_d;
            seg_ready_q <= seg_ready_d;
            bcd_valid_q <= bcd_valid_d;
        end
    end

    assign seg_ready = seg_ready_q;
    assign bcd_valid = bcd_valid_q;
    assign bcd_out   = bcd_out_q;
    assign frame_err = frame_err_q;
    assign digit_cnt = cnt_q;

endmodule

// File: tb/tb_sevenseg_to_bcd_capture.sv
// -----------------------------------------------------------------------------
// Testbench for sevenseg_to_bcd_capture: a 4-digit instance and a 1-digit
// instance. Expected frames are queued as digits are sent and compared when
// the DUT raises bcd_valid.
// -----------------------------------------------------------------------------
module tb_sevenseg_to_bcd_capture;

    logic        clk = 1'b0;
    logic        rst;

    logic        seg_valid;
    logic [6:0]  seg_in;
    logic        seg_ready;
    logic        bcd_valid;
    logic        bcd_ready;
    logic [15:0] bcd_out;
    logic        frame_err;
    logic [3:0]  digit_cnt;

    logic        seg_valid1;
    logic [6:0]  seg_in1;
    logic        seg_ready1;
    logic        bcd_valid1;
    logic        bcd_ready1;
    logic [3:0]  bcd_out1;
    logic        frame_err1;
    logic [3:0]  digit_cnt1;

    int vectors     = 0;
    int miscompares = 0;

    logic [16:0] exp_q[$];
    logic [4:0]  exp1_q[$];
    logic        prev_v  = 1'b0;
    logic        prev_v1 = 1'b0;

    logic [15:0] m_frame;
    logic        m_err;
    int          m_cnt;

    logic [6:0]  codes[28];

    always #5 clk = ~clk;

    sevenseg_to_bcd_capture #(.NUM_DIGITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_valid (seg_valid),
        .seg_in    (seg_in),
        .seg_ready (seg_ready),
        .bcd_valid (bcd_valid),
        .bcd_ready (bcd_ready),
        .bcd_out   (bcd_out),
        .frame_err (frame_err),
        .digit_cnt (digit_cnt)
    );

    sevenseg_to_bcd_capture #(.NUM_DIGITS(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .seg_valid (seg_valid1),
        .seg_in    (seg_in1),
        .seg_ready (seg_ready1),
        .bcd_valid (bcd_valid1),
        .bcd_ready (bcd_ready1),
        .bcd_out   (bcd_out1),
        .frame_err (frame_err1),
        .digit_cnt (digit_cnt1)
    );

    // Reference decode: index of the pattern in the glyph list, else F + illegal.
    function automatic logic [4:0] ref_dec(input logic [6:0] s);
        logic [6:0] glyphs[10];
        logic [4:0] r;
        glyphs = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                   7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
        r = 5'h1F;
        for (int k = 0; k < 10; k++) begin
            if (glyphs[k] == s) r = {1'b0, 4'(k)};
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        vectors++;
        miscompares++;
        $error("FAIL %s: observed timeout/unexpected expected event", tag);
    endtask

    // Advance one cycle and compare any frame that has just appeared.
    task automatic tick();
        logic [16:0] e;
        logic [4:0]  e1;
        @(posedge clk);
        #1;
        if (bcd_valid && !prev_v) begin
            if (exp_q.size() == 0) begin
                fail_now("frame_unexpected");
            end else begin
                e = exp_q.pop_front();
                chk("frame_out", 32'(bcd_out), 32'(e[15:0]));
                chk("frame_err", 32'(frame_err), 32'(e[16]));
            end
        end
        if (bcd_valid1 && !prev_v1) begin
            if (exp1_q.size() == 0) begin
                fail_now("frame1_unexpected");
            end else begin
                e1 = exp1_q.pop_front();
                chk("frame1_out", 32'(bcd_out1), 32'(e1[3:0]));
                chk("frame1_err", 32'(frame_err1), 32'(e1[4]));
            end
        end
        prev_v  = bcd_valid;
        prev_v1 = bcd_valid1;
    endtask

    task automatic model_reset();
        m_frame = 16'h0000;
        m_err   = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic send(input logic [6:0] s);
        int n;
        logic [4:0] d;
        seg_in    = s;
        seg_valid = 1'b1;
        n = 0;
        while (!seg_ready && n < 50) begin
            bcd_ready = 1'b1;
            tick();
            n++;
        end
        if (!seg_ready) begin
            fail_now("seg_ready_timeout");
        end else begin
            d       = ref_dec(s);
            m_frame = {m_frame[11:0], d[3:0]};
            m_err   = m_err | d[4];
            m_cnt++;
            if (m_cnt == 4) begin
                exp_q.push_back({m_err, m_frame});
                model_reset();
            end
            tick();
        end
        seg_valid = 1'b0;
    endtask

    task automatic send1(input logic [6:0] s);
        int n;
        seg_in1    = s;
        seg_valid1 = 1'b1;
        n = 0;
        while (!seg_ready1 && n < 50) begin
            tick();
            n++;
        end
        if (!seg_ready1) begin
            fail_now("seg_ready1_timeout");
        end else begin
            exp1_q.push_back(ref_dec(s));
            tick();
        end
        seg_valid1 = 1'b0;
    endtask

    initial begin
        logic [6:0] r;
        rst        = 1'b1;
        seg_valid  = 1'b0;
        seg_in     = 7'h00;
        bcd_ready  = 1'b1;
        seg_valid1 = 1'b0;
        seg_in1    = 7'h00;
        bcd_ready1 = 1'b1;
        model_reset();
        tick();
        tick();
        chk("rst_seg_ready", 32'(seg_ready), 32'd1);
        chk("rst_bcd_valid", 32'(bcd_valid), 32'd0);
        chk("rst_bcd_out",   32'(bcd_out),   32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_digit_cnt", 32'(digit_cnt), 32'd0);
        rst = 1'b0;

        // 1: back-to-back digits, ready downstream
        send(7'h7E); send(7'h30); send(7'h6D); send(7'h79);
        chk("t1_bcd_valid", 32'(bcd_valid), 32'd1);
        chk("t1_seg_ready_low", 32'(seg_ready), 32'd0);
        tick();
        chk("t1_seg_ready_back", 32'(seg_ready), 32'd1);
        chk("t1_valid_drop", 32'(bcd_valid), 32'd0);

        // 2: downstream stalls for 5 cycles
        bcd_ready = 1'b0;
        send(7'h33); send(7'h5B); send(7'h5F); send(7'h70);
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_out", 32'(bcd_out), 32'h4567);
            chk("t2_hold_seg_ready", 32'(seg_ready), 32'd0);
            chk("t2_hold_valid", 32'(bcd_valid), 32'd1);
            tick();
        end
        bcd_ready = 1'b1;
        chk("t2_still_blocked", 32'(seg_ready), 32'd0);
        tick();
        chk("t2_seg_ready_back", 32'(seg_ready), 32'd1);
        chk("t2_out_kept", 32'(bcd_out), 32'h4567);

        // 3: illegal patterns, then a clean frame
        send(7'h7F); send(7'h4F); send(7'h7B); send(7'h00);
        send(7'h30); send(7'h30); send(7'h30); send(7'h30);

        // 4: reset mid-frame
        send(7'h7E); send(7'h30);
        chk("t4_cnt_before", 32'(digit_cnt), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk("t4_cnt_after", 32'(digit_cnt), 32'd0);
        chk("t4_out_after", 32'(bcd_out), 32'd0);
        chk("t4_ready_after", 32'(seg_ready), 32'd1);
        send(7'h6D); send(7'h79); send(7'h33); send(7'h5B);
        tick();

        // 4b: reset while a frame is held
        bcd_ready = 1'b0;
        send(7'h70); send(7'h70); send(7'h70); send(7'h70);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4b_valid", 32'(bcd_valid), 32'd0);
        chk("t4b_ready", 32'(seg_ready), 32'd1);
        chk("t4b_err", 32'(frame_err), 32'd0);
        bcd_ready = 1'b1;

        // 5: legal and random illegal codes with random gaps and ready
        codes[0] = 7'h7E; codes[1] = 7'h30; codes[2] = 7'h6D; codes[3] = 7'h79;
        codes[4] = 7'h33; codes[5] = 7'h5B; codes[6] = 7'h5F; codes[7] = 7'h70;
        codes[8] = 7'h7F; codes[9] = 7'h7B;
        for (int i = 10; i < 26; i++) begin
            do begin
                r = 7'($urandom_range(0, 127));
            end while (ref_dec(r) != 5'h1F);
            codes[i] = r;
        end
        codes[26] = 7'h5F;
        codes[27] = 7'h30;
        for (int i = 27; i > 0; i--) begin
            int j;
            j = $urandom_range(0, i);
            r = codes[i]; codes[i] = codes[j]; codes[j] = r;
        end
        for (int i = 0; i < 28; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            bcd_ready = ($urandom_range(0, 3) != 0);
            send(codes[i]);
        end
        bcd_ready = 1'b1;
        tick();
        tick();

        // 6: single-digit instance
        send1(7'h5F);
        chk("t6_valid", 32'(bcd_valid1), 32'd1);
        chk("t6_cnt", 32'(digit_cnt1), 32'd0);
        send1(7'h00);
        send1(7'h7B);
        tick();
        tick();

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        chk("sb1_empty", 32'(exp1_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sevenseg_to_bcd_capture.md
Name: sevenseg_to_bcd_capture

Overview:
- Inverse of the team's BCD-to-7-segment decoder.
- Accepts a stream of 7-segment patterns (one digit per handshake), decodes each back to a 4-bit BCD value, and packs NUM_DIGITS digits into one frame.
- Presents each frame on a valid/ready output with a frame error flag.
- Sits between a display-tap or segment-capture path and downstream BCD consumers (checkers, counters, scoreboards).

Parameters:
NUM_DIGITS, 4, digits per frame; legal range 1..8.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
seg_valid  input  1  seg_in holds a pattern to transfer
seg_in  input  7  pattern {a,b,c,d,e,f,g}; bit6 = a, bit0 = g; active-high segments
seg_ready  output  1  block can accept a pattern this cycle
bcd_valid  output  1  completed frame on bcd_out
bcd_ready  input  1  downstream accepts the frame
bcd_out  output  4*NUM_DIGITS  packed frame; first-received digit in the MS nibble
frame_err  output  1  at least one digit in the frame was an illegal pattern; valid with bcd_valid
digit_cnt  output  4  digits accepted in the current frame, 0..NUM_DIGITS-1

Behaviour:
- Single clock domain. Reset is synchronous and active-high on rst; all state changes on the rising edge of clk.
- Reset values: seg_ready=1, bcd_valid=0, bcd_out=0, frame_err=0, digit_cnt=0, state=COLLECT.
- Decode table, exact match only (hex of seg_in):
  - 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9.
  - Every other pattern is illegal, including 4F (the decoder's glyph for inputs 10..15) and 00 (blank).
- Illegal digit handling: the digit is stored as 4'hF and the frame error accumulator is set.
- Transfer rule: a digit transfers on an edge where seg_valid and seg_ready are both 1. seg_in is sampled only on that edge.
- State COLLECT (seg_ready=1, bcd_valid=0):
  - On transfer, shift the decoded nibble into the frame register: shift left by 4, new nibble in the LS position. digit_cnt increments by 1.
  - The error accumulator ORs in the illegal flag.
  - On the transfer that completes digit NUM_DIGITS: go to HOLD, digit_cnt returns to 0.
  - The completed frame appears on bcd_out with bcd_valid=1 on the cycle after that edge. Latency from last digit to bcd_valid is 1 cycle.
- State HOLD (seg_ready=0, bcd_valid=1):
  - bcd_out and frame_err are stable; seg_in is ignored.
  - On an edge with bcd_ready=1: go to COLLECT and clear the error accumulator.
  - bcd_out keeps its last value until the next frame completes.
  - seg_ready returns to 1 the following cycle. There is no same-cycle bypass, so max throughput is one frame per NUM_DIGITS+1 cycles.
- bcd_ready while in COLLECT is ignored.
- seg_valid may be deasserted between digits for any number of cycles; the partial frame is retained.
- NUM_DIGITS=1: every transfer completes a frame.
- Reset mid-frame or mid-HOLD discards the partial or pending frame; all outputs return to reset values on the next edge.
- Outputs are registered; there is no combinational path from seg_in to any output.

Test Plan:
1. Reset, then send 7E,30,6D,79 back-to-back with bcd_ready=1 -> one cycle after the 4th transfer: bcd_valid=1, bcd_out=16'h0123, frame_err=0. seg_ready=0 for exactly 1 cycle.
2. Send 33,5B,5F,70 with bcd_ready held 0 for 5 cycles -> bcd_out=16'h4567 stable throughout HOLD; seg_ready=0 until 1 cycle after bcd_ready rises.
3. Send 7F,4F,7B,00 -> bcd_out=16'h8F9F, frame_err=1. Next frame 30,30,30,30 -> 16'h1111, frame_err=0.
4. Send 7E,30, assert rst for 1 cycle, then send 6D,79,33,5B -> bcd_out=16'h2345; digit_cnt=0 right after reset.
5. Random gaps on seg_valid, all 10 legal codes plus 16 random illegal codes, compared against a reference model -> every frame matches and frame_err matches exactly.
6. NUM_DIGITS=1 build: send 5F -> bcd_valid=1, bcd_out=4'h6 one cycle later.
